fp_normalizer: RTL and testbench



---
 rtl/fp_normalizer.sv | 156 +++++++++++++++
 tb/tb_fp_normalizer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization stage of the single-precision adder.
// It takes the mantissa sum, the carry-out, the aligned exponent and the sign,
// and packs them into an IEEE-754 word. Rounding is truncation. Leading zeros
// are removed one bit per cycle. The input and output both use valid/ready.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] sum,
    input  logic        cout,
    input  logic [7:0]  exp,
    input  logic        sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    logic [23:0] man_r;
    logic [7:0]  e_r;
    logic        s_r;
    logic        out_valid_r;
    logic [31:0] result_r;
    logic        overflow_r;
    logic        zero_r;

    logic [7:0]  e_eff_s;
    logic [7:0]  e_inc_s;
    logic [23:0] man_carry_s;
    logic [23:0] man_next_s;
    logic [7:0]  e_dec_s;

    // Packs a word. A mantissa without the hidden bit gives a denormal (exp field 0).
    function automatic logic [31:0] pack(input logic s, input logic [7:0] e,
                                         input logic [23:0] m);
        pack = {s, (m[23] ? e : 8'h00), m[22:0]};
    endfunction

    // Operand-side helpers: effective exponent, carry renormalisation, shift step.
    always_comb begin
        e_eff_s     = (exp == 8'h00) ? 8'h01 : exp;
        e_inc_s     = e_eff_s + 8'h01;
        man_carry_s = {1'b1, sum[23:1]};
        man_next_s  = {man_r[22:0], 1'b0};
        e_dec_s     = e_r - 8'h01;
    end

    // Input is accepted only in IDLE, and never while reset is asserted.
    always_comb begin
        in_ready = (state_r == IDLE) && !rst;
    end

    // Normalization FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            man_r       <= 24'h000000;
            e_r         <= 8'h00;
            s_r         <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= 32'h00000000;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        s_r <= sign;
                        if (exp == 8'hFF) begin
                            // Inf/NaN operand: the fraction is passed through unchanged.
                            result_r    <= {sign, 8'hFF, sum[22:0]};
                            overflow_r  <= 1'b0;
                            zero_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (cout) begin
                            man_r <= man_carry_s;
                            e_r   <= e_inc_s;
                            if (e_inc_s == 8'hFF) begin
                                result_r   <= {sign, 8'hFF, 23'h000000};
                                overflow_r <= 1'b1;
                            end else begin
                                result_r   <= pack(sign, e_inc_s, man_carry_s);
                                overflow_r <= 1'b0;
                            end
                            zero_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (sum == 24'h000000) begin
                            result_r    <= {sign, 31'h00000000};
                            overflow_r  <= 1'b0;
                            zero_r      <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (sum[23] || (e_eff_s == 8'h01)) begin
                            man_r       <= sum;
                            e_r         <= e_eff_s;
                            result_r    <= pack(sign, e_eff_s, sum);
                            overflow_r  <= 1'b0;
                            zero_r      <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            man_r   <= sum;
                            e_r     <= e_eff_s;
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    man_r <= man_next_s;
                    e_r   <= e_dec_s;
                    // Stop on a restored hidden bit, or clamp at the denormal exponent.
                    if (man_next_s[23] || (e_dec_s == 8'h01)) begin
                        result_r    <= pack(s_r, e_dec_s, man_next_s);
                        overflow_r  <= 1'b0;
                        zero_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_fp_normalizer.sv
// Testbench for fp_normalizer. It applies directed vectors from a table and
// then runs hand-written backpressure and mid-shift reset sequences.
module tb_fp_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] sum;
    logic        cout;
    logic [7:0]  exp;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    fp_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .exp       (exp),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] sum;
        logic        cout;
        logic [7:0]  exp;
        logic        sign;
        logic [31:0] res;
        logic        ovf;
        logic        zro;
        int          n;      // shift count; 0 = settles at the accept edge
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_in_ready", {31'd0, ok}, 32'd1);
    endtask

    task automatic apply(input vec_t v, input int idx);
        int lat;
        bit seen;
        wait_ready();
        sum      = v.sum;
        cout     = v.cout;
        exp      = v.exp;
        sign     = v.sign;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk($sformatf("v%0d_out_valid", idx), {31'd0, seen}, 32'd1);
        if (v.n > 0) chk($sformatf("v%0d_latency", idx), lat, v.n);
        else         chk($sformatf("v%0d_latency_le1", idx), {31'd0, (lat <= 1)}, 32'd1);
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_overflow", idx), {31'd0, overflow}, {31'd0, v.ovf});
        chk($sformatf("v%0d_zero", idx), {31'd0, zero}, {31'd0, v.zro});
        chk($sformatf("v%0d_in_ready_done", idx), {31'd0, in_ready}, 32'd0);
        @(posedge clk);   // handshake edge, out_ready is high
        @(negedge clk);
        chk($sformatf("v%0d_out_valid_drop", idx), {31'd0, out_valid}, 32'd0);
        chk($sformatf("v%0d_in_ready_back", idx), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        //        sum         cout  exp    sign  result        ovf   zro   n
        vecs[0]  = '{24'h800000, 1'b0, 8'h7F, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0};
        vecs[1]  = '{24'h000000, 1'b1, 8'h7F, 1'b0, 32'h40000000, 1'b0, 1'b0, 0};
        vecs[2]  = '{24'hFFFFFF, 1'b1, 8'hFE, 1'b0, 32'h7F800000, 1'b1, 1'b0, 0};
        vecs[3]  = '{24'h000001, 1'b0, 8'h7F, 1'b0, 32'h34000000, 1'b0, 1'b0, 23};
        vecs[4]  = '{24'h000000, 1'b0, 8'h7F, 1'b1, 32'h80000000, 1'b0, 1'b1, 0};
        vecs[5]  = '{24'h000100, 1'b0, 8'h03, 1'b0, 32'h00000400, 1'b0, 1'b0, 2};
        vecs[6]  = '{24'h400000, 1'b0, 8'h00, 1'b0, 32'h00400000, 1'b0, 1'b0, 0};
        vecs[7]  = '{24'h400001, 1'b0, 8'hFF, 1'b1, 32'hFFC00001, 1'b0, 1'b0, 0};
        vecs[8]  = '{24'h400000, 1'b0, 8'h7F, 1'b1, 32'hBF000000, 1'b0, 1'b0, 1};
        vecs[9]  = '{24'h000002, 1'b1, 8'h00, 1'b0, 32'h01000001, 1'b0, 1'b0, 0};
        vecs[10] = '{24'h0000FF, 1'b0, 8'h05, 1'b0, 32'h00000FF0, 1'b0, 1'b0, 4};
        vecs[11] = '{24'h000000, 1'b1, 8'hFF, 1'b0, 32'h7F800000, 1'b0, 1'b0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = 24'h000000;
        cout      = 1'b0;
        exp       = 8'h00;
        sign      = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h00000000);
        chk("rst_flags", {30'd0, overflow, zero}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) apply(vecs[i], i);

        // Backpressure: result held and input ignored while out_ready is low
        out_ready = 1'b0;
        wait_ready();
        sum = 24'h800000; cout = 1'b0; exp = 8'h7F; sign = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 sum = 24'h000001; exp = 8'h10; sign = 1'b1;   // must be ignored
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_result", k), result, 32'h3F800000);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_no_extra_result", {31'd0, out_valid}, 32'd0);

        // Reset five cycles into a 23-shift operation
        wait_ready();
        sum = 24'h000001; cout = 1'b0; exp = 8'h7F; sign = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'h00000000);
        rst = 1'b0;
        begin
            bit leaked;
            leaked = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (out_valid) leaked = 1'b1;
            end
            chk("mid_rst_discarded", {31'd0, leaked}, 32'd0);
        end
        chk("mid_rst_idle_ready", {31'd0, in_ready}, 32'd1);
        apply(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
